sprite_addr_cal: RTL and testbench

- Per-sprite pixel-address calculator used by the block/sprite display engines (one instance per child sprite per buffer).
- Takes the current VGA raster position, a pattern descriptor and a sprite state word.
- Asserts valid when the raster pixel lies inside the visible sprite.
- When valid, outputs the pixel-memory address of the colour index for that pixel; results are registered with one cycle latency.

---
 rtl/sprite_pkg.sv | 41 ++++
 rtl/sprite_addr_cal_if.sv | 26 ++
 rtl/sprite_axis_map.sv | 46 ++++
 rtl/sprite_addr_cal.sv | 89 ++++++++
 tb/tb_sprite_addr_cal.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite pixel-address calculator.
//   - pattern_info / sprite_info field positions and typedefs
//   - datapath widths
//   - log2 helper for power-of-two tile sizes
package sprite_pkg;

    localparam int ADDR_W = 16;   // base address / output address width
    localparam int POS_W  = 10;   // raster and sprite position width
    localparam int FLD_W  = 16;   // width of every pattern_info field

    // pattern_info = {base_addr, tile_w, tile_h, disp_w, disp_h}
    localparam int BASE_MSB   = 79;
    localparam int BASE_LSB   = 64;
    localparam int TILE_W_MSB = 63;
    localparam int TILE_W_LSB = 48;
    localparam int TILE_H_MSB = 47;
    localparam int TILE_H_LSB = 32;
    localparam int DISP_W_MSB = 31;
    localparam int DISP_W_LSB = 16;
    localparam int DISP_H_MSB = 15;
    localparam int DISP_H_LSB = 0;

    // sprite_info = {visible, hflip, x, y, reserved}
    localparam int VIS_BIT  = 31;
    localparam int FLIP_BIT = 30;
    localparam int X_MSB    = 29;
    localparam int Y_MSB    = 19;

    typedef logic [79:0] pattern_info_t;
    typedef logic [31:0] sprite_info_t;

    // Index of the highest set bit. For a power-of-two tile size this is
    // log2(size), which turns the row multiply into a shift.
    function automatic logic [3:0] log2_pow2(input logic [FLD_W-1:0] v);
        log2_pow2 = '0;
        for (int i = 0; i < FLD_W; i++) begin
            if (v[i]) log2_pow2 = i[3:0];
        end
    endfunction

endpackage

// File: rtl/sprite_addr_cal_if.sv
// Raster/descriptor inputs and registered address outputs of one sprite
// address calculator.
//   master : drives pattern_info, sprite_info, hcount, vcount;
//            receives addr_output, valid
//   slave  : the calculator itself
interface sprite_addr_cal_if;
    import sprite_pkg::*;

    pattern_info_t      pattern_info;
    sprite_info_t       sprite_info;
    logic [POS_W-1:0]   hcount;
    logic [POS_W-1:0]   vcount;
    logic [ADDR_W-1:0]  addr_output;
    logic               valid;

    modport master (
        output pattern_info, sprite_info, hcount, vcount,
        input  addr_output, valid
    );

    modport slave (
        input  pattern_info, sprite_info, hcount, vcount,
        output addr_output, valid
    );

endinterface

// File: rtl/sprite_axis_map.sv
// One axis of the sprite hit test and tile-coordinate mapping.
//   pos        : raster coordinate on this axis
//   origin     : sprite origin on this axis
//   disp_len   : displayed extent (0 means nothing is displayed)
//   tile_len   : tile size, power of two 1..512
//   flip       : mirror the coordinate inside the tile
//   in_range   : origin <= pos < origin + disp_len (no wrap at 1024)
//   tile_coord : (pos - origin) mod tile_len, mirrored when flip=1
module sprite_axis_map
    import sprite_pkg::*;
(
    input  logic [POS_W-1:0]  pos,
    input  logic [POS_W-1:0]  origin,
    input  logic [FLD_W-1:0]  disp_len,
    input  logic [FLD_W-1:0]  tile_len,
    input  logic              flip,
    output logic              in_range,
    output logic [FLD_W-1:0]  tile_coord
);

    logic [16:0]      pos_ext;
    logic [16:0]      end_ext;
    logic [16:0]      delta;
    logic [FLD_W-1:0] tile_mask;
    logic [FLD_W-1:0] raw_coord;
    logic             unused_delta_msb;

    // 17-bit arithmetic: a sprite reaching past column 1023 must not wrap
    // its right edge back to the left side of the screen.
    assign pos_ext  = {7'b0, pos};
    assign end_ext  = {7'b0, origin} + {1'b0, disp_len};
    assign delta    = pos_ext - {7'b0, origin};
    assign in_range = (pos >= origin) && (pos_ext < end_ext);

    assign tile_mask        = tile_len - 16'd1;
    assign raw_coord        = delta[FLD_W-1:0] & tile_mask;
    assign unused_delta_msb = delta[16];

    // NOTE: assign a default first in every always_comb so no path leaves
    // the output unassigned, which would infer a latch.
    always_comb begin
        tile_coord = raw_coord;
        if (flip) tile_coord = tile_mask - raw_coord;
    end

endmodule

// File: rtl/sprite_addr_cal.sv
// Per-sprite pixel-address calculator. Tests whether the current raster
// pixel lies inside the visible, tiled sprite and, if so, produces the
// pixel-memory address of its colour index. One cycle latency.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : sprite_addr_cal_if.slave (descriptors, raster position,
//           registered addr_output / valid)
module sprite_addr_cal
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    sprite_addr_cal_if.slave   bus
);

    logic [ADDR_W-1:0] base_addr;
    logic [FLD_W-1:0]  tile_w;
    logic [FLD_W-1:0]  tile_h;
    logic [FLD_W-1:0]  disp_w;
    logic [FLD_W-1:0]  disp_h;
    logic              visible;
    logic              hflip;
    logic [POS_W-1:0]  spr_x;
    logic [POS_W-1:0]  spr_y;
    logic              unused_reserved;

    logic              h_hit;
    logic              v_hit;
    logic [FLD_W-1:0]  tx;
    logic [FLD_W-1:0]  ty;
    logic              hit;
    logic [3:0]        row_shift;
    logic [ADDR_W-1:0] addr;

    assign base_addr = bus.pattern_info[BASE_MSB:BASE_LSB];
    assign tile_w    = bus.pattern_info[TILE_W_MSB:TILE_W_LSB];
    assign tile_h    = bus.pattern_info[TILE_H_MSB:TILE_H_LSB];
    assign disp_w    = bus.pattern_info[DISP_W_MSB:DISP_W_LSB];
    assign disp_h    = bus.pattern_info[DISP_H_MSB:DISP_H_LSB];

    assign visible   = bus.sprite_info[VIS_BIT];
    assign hflip     = bus.sprite_info[FLIP_BIT];
    assign spr_x     = bus.sprite_info[X_MSB -: POS_W];
    assign spr_y     = bus.sprite_info[Y_MSB -: POS_W];
    assign unused_reserved = ^bus.sprite_info[Y_MSB-POS_W:0];

    sprite_axis_map u_h_axis (
        .pos        (bus.hcount),
        .origin     (spr_x),
        .disp_len   (disp_w),
        .tile_len   (tile_w),
        .flip       (hflip),
        .in_range   (h_hit),
        .tile_coord (tx)
    );

    // Vertical flip is not supported by the sprite format.
    sprite_axis_map u_v_axis (
        .pos        (bus.vcount),
        .origin     (spr_y),
        .disp_len   (disp_h),
        .tile_len   (tile_h),
        .flip       (1'b0),
        .in_range   (v_hit),
        .tile_coord (ty)
    );

    // Empty extents fall out naturally: disp_len=0 makes in_range false.
    assign hit       = visible & h_hit & v_hit;
    // tile_w is a power of two, so ty*tile_w is a shift by log2(tile_w).
    assign row_shift = log2_pow2(tile_w);
    assign addr      = base_addr + (ty << row_shift) + tx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.valid       <= 1'b0;
            bus.addr_output <= '0;
        end else if (hit) begin
            bus.valid       <= 1'b1;
            bus.addr_output <= addr;
        end else begin
            bus.valid       <= 1'b0;
            bus.addr_output <= '0;
        end
    end

endmodule

// File: tb/tb_sprite_addr_cal.sv
// Directed self-checking bench for sprite_addr_cal. Each task drives one
// scenario and compares {valid, addr_output} against hand-computed values.
module tb_sprite_addr_cal;
    import sprite_pkg::*;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    sprite_addr_cal_if bus ();

    sprite_addr_cal dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pattern_info_t pat(input int b, tw, th, dw, dh);
        return {b[15:0], tw[15:0], th[15:0], dw[15:0], dh[15:0]};
    endfunction

    function automatic sprite_info_t spr(input int vis, fl, x, y);
        return {vis[0], fl[0], x[9:0], y[9:0], 10'h2a5};
    endfunction

    // Drive inputs away from the edge, clock once, sample 1 time unit later.
    task automatic apply(input pattern_info_t p, input sprite_info_t s,
                         input int h, input int v);
        @(negedge clk);
        bus.pattern_info = p;
        bus.sprite_info  = s;
        bus.hcount       = h[9:0];
        bus.vcount       = v[9:0];
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic ev, input int ea);
        logic [16:0] exp_v;
        exp_v = {ev, ea[15:0]};
        total_cnt++;
        if ({bus.valid, bus.addr_output} !== exp_v)
            $display("FAIL %s: got valid=%b addr=%0d, want valid=%b addr=%0d",
                     name, bus.valid, bus.addr_output, ev, ea[15:0]);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({bus.valid, bus.addr_output} !== 17'd0)
            $display("FAIL reset_state: got valid=%b addr=%0d, want valid=0 addr=0",
                     bus.valid, bus.addr_output);
        else
            pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        pattern_info_t p = pat(256, 16, 16, 16, 16);
        apply(p, spr(1, 0, 100, 50), 100, 50);  expect_out("basic_origin", 1'b1, 256);
        apply(p, spr(1, 0, 100, 50), 115, 65);  expect_out("basic_corner", 1'b1, 511);
        apply(p, spr(1, 0, 100, 50), 116, 65);  expect_out("basic_right_edge", 1'b0, 0);
        apply(p, spr(1, 0, 100, 50), 99, 50);   expect_out("basic_left_edge", 1'b0, 0);
    endtask

    task automatic test_flip();
        pattern_info_t p = pat(256, 16, 16, 16, 16);
        apply(p, spr(1, 1, 100, 50), 100, 50);  expect_out("flip_left", 1'b1, 271);
        apply(p, spr(1, 1, 100, 50), 115, 50);  expect_out("flip_right", 1'b1, 256);
        apply(p, spr(1, 1, 100, 50), 103, 52);  expect_out("flip_inner", 1'b1, 300);
    endtask

    task automatic test_hrepeat();
        pattern_info_t p = pat(1280, 16, 16, 48, 16);
        apply(p, spr(1, 0, 0, 0), 37, 2);       expect_out("hrep_third_tile", 1'b1, 1317);
        apply(p, spr(1, 0, 0, 0), 48, 2);       expect_out("hrep_past_end", 1'b0, 0);
    endtask

    task automatic test_vrepeat();
        pattern_info_t p = pat(2048, 16, 16, 16, 32);
        apply(p, spr(1, 0, 0, 0), 3, 20);       expect_out("vrep_second_tile", 1'b1, 2115);
        apply(p, spr(1, 0, 0, 0), 3, 32);       expect_out("vrep_past_end", 1'b0, 0);
        // 8x4 tile: ty = 6&3 = 2, shift by 3 -> 16; tx = 13&7 = 5.
        apply(pat(100, 8, 4, 16, 8), spr(1, 0, 0, 0), 13, 6);
        expect_out("vrep_small_tile", 1'b1, 121);
    endtask

    task automatic test_invisible();
        apply(pat(256, 16, 16, 16, 16), spr(0, 0, 100, 50), 105, 55);
        expect_out("invisible", 1'b0, 0);
        apply(pat(256, 16, 16, 0, 16), spr(1, 0, 100, 50), 100, 50);
        expect_out("zero_disp_w", 1'b0, 0);
    endtask

    task automatic test_boundary();
        pattern_info_t p = pat(0, 16, 16, 128, 16);
        apply(p, spr(1, 0, 1000, 0), 1023, 0);  expect_out("edge_col_1023", 1'b1, 7);
        apply(p, spr(1, 0, 1000, 0), 3, 0);     expect_out("no_wrap_col_3", 1'b0, 0);
        // Address arithmetic wraps modulo 2^16.
        apply(pat(65530, 16, 16, 16, 16), spr(1, 0, 0, 0), 9, 0);
        expect_out("addr_wrap", 1'b1, 3);
    endtask

    task automatic test_reset_midstream();
        apply(pat(256, 16, 16, 16, 16), spr(1, 0, 100, 50), 101, 51);
        expect_out("pre_reset", 1'b1, 273);
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_reset", 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_out("post_reset_resume", 1'b1, 273);
    endtask

    initial begin
        pass_cnt         = 0;
        total_cnt        = 0;
        reset            = 1'b1;
        bus.pattern_info = '0;
        bus.sprite_info  = '0;
        bus.hcount       = '0;
        bus.vcount       = '0;

        test_reset();
        test_basic();
        test_flip();
        test_hrepeat();
        test_vrepeat();
        test_invisible();
        test_boundary();
        test_reset_midstream();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
